// File: rtl/score_argmax_scheduler.sv
// score_argmax_scheduler
// Shares one pipelined scoring datapath across all classes. It issues one class
// index per cycle, follows the returning scores with a tag pipeline, and keeps a
// running argmax. The result is held on a valid/ready port until it is accepted.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   start                 one-cycle inference request (idle, or HOLD back-to-back)
//   cls_sel/cls_sel_valid class index issued to the counter-bank mux
//   score                 biased unsigned score returned LATENCY cycles after issue
//   busy                  sequence in progress or result pending
//   pred/pred_score       argmax class and its score
//   pred_valid/pred_ready result handshake
module score_argmax_scheduler #(
  parameter int unsigned NUM_CLASSES = 10,
  parameter int unsigned LATENCY     = 2,
  parameter int unsigned CLS_W       = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [CLS_W-1:0] cls_sel,
  output logic             cls_sel_valid,
  input  logic [7:0]       score,
  output logic             busy,
  output logic [CLS_W-1:0] pred,
  output logic [7:0]       pred_score,
  output logic             pred_valid,
  input  logic             pred_ready
);

  localparam logic [CLS_W-1:0] LAST_CLS = CLS_W'(NUM_CLASSES - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_HOLD} state_t;

  state_t           r_state;
  logic [CLS_W-1:0] r_cls_sel;
  logic             r_cls_sel_valid;
  logic             r_busy;
  logic [CLS_W-1:0] r_best_idx;
  logic [7:0]       r_best_score;
  logic             r_pred_valid;

  // Tag pipeline: stage LATENCY-1 names the class that 'score' belongs to.
  logic             r_tag_vld [LATENCY];
  logic [CLS_W-1:0] r_tag_idx [LATENCY];

  logic             w_ret_vld;
  logic [CLS_W-1:0] w_ret_idx;
  logic             w_take;

  assign w_ret_vld = r_tag_vld[LATENCY-1];
  assign w_ret_idx = r_tag_idx[LATENCY-1];
  // Class 0 seeds the argmax; later classes need a strictly larger score so ties keep the lower index.
  assign w_take    = w_ret_vld && ((w_ret_idx == '0) || (score > r_best_score));

  // Tag stage 0 captures the live issue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tag_vld[0] <= 1'b0;
      r_tag_idx[0] <= '0;
    end else begin
      r_tag_vld[0] <= r_cls_sel_valid;
      r_tag_idx[0] <= r_cls_sel;
    end
  end

  // Remaining tag stages shift toward the output.
  for (genvar g = 1; g < LATENCY; g++) begin : g_tag
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_tag_vld[g] <= 1'b0;
        r_tag_idx[g] <= '0;
      end else begin
        r_tag_vld[g] <= r_tag_vld[g-1];
        r_tag_idx[g] <= r_tag_idx[g-1];
      end
    end
  end

  // Sequencer FSM with registered outputs and argmax tracking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state         <= S_IDLE;
      r_cls_sel       <= '0;
      r_cls_sel_valid <= 1'b0;
      r_busy          <= 1'b0;
      r_best_idx      <= '0;
      r_best_score    <= '0;
      r_pred_valid    <= 1'b0;
    end else begin
      if (w_take) begin
        r_best_idx   <= w_ret_idx;
        r_best_score <= score;
      end

      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state         <= S_ISSUE;
            r_cls_sel       <= '0;
            r_cls_sel_valid <= 1'b1;
            r_busy          <= 1'b1;
          end
        end
        S_ISSUE: begin
          if (r_cls_sel == LAST_CLS) begin
            r_state         <= S_DRAIN;
            r_cls_sel       <= '0;
            r_cls_sel_valid <= 1'b0;
          end else begin
            r_cls_sel <= CLS_W'(r_cls_sel + 1'b1);
          end
        end
        S_DRAIN: begin
          // The last class's score is compared on this same edge.
          if (w_ret_vld && (w_ret_idx == LAST_CLS)) begin
            r_state      <= S_HOLD;
            r_pred_valid <= 1'b1;
          end
        end
        S_HOLD: begin
          if (pred_ready) begin
            r_pred_valid <= 1'b0;
            if (start) begin
              // Back-to-back: first issue right after the handshake edge.
              r_state         <= S_ISSUE;
              r_cls_sel       <= '0;
              r_cls_sel_valid <= 1'b1;
            end else begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end
          end
        end
        default: begin
          r_state         <= S_IDLE;
          r_cls_sel_valid <= 1'b0;
          r_busy          <= 1'b0;
          r_pred_valid    <= 1'b0;
        end
      endcase
    end
  end

  assign cls_sel       = r_cls_sel;
  assign cls_sel_valid = r_cls_sel_valid;
  assign busy          = r_busy;
  assign pred          = r_best_idx;
  assign pred_score    = r_best_score;
  assign pred_valid    = r_pred_valid;

endmodule

// File: doc/score_argmax_scheduler.md
# score_argmax_scheduler

Sequencer that shares the single `counter_adder` scoring datapath across all output classes of the classifier. On a start pulse it presents one class index per cycle to the per-class counter bank, which feeds that class's 13 counters into `counter_adder`. It tracks the pipelined scores as they return and keeps a running argmax. It then holds the predicted digit and its score on a valid/ready output until the consumer accepts it.

## Interface
- `NUM_CLASSES`, default 10: number of classes scored per inference. Range 2..2^CLS_W.
- `LATENCY`, default 2: register stages between `cls_sel` and a valid `score` (matches `counter_adder`).
- `CLS_W`, default 4: width of class indices.

- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: one-cycle request to begin an inference. Ignored unless idle, except for the HOLD back-to-back case defined below.
- `cls_sel` out CLS_W: class index driven to the counter-bank mux.
- `cls_sel_valid` out 1: `cls_sel` is a live issue this cycle.
- `score` in 8: `counter_adder` output. Unsigned, biased; 128 = zero.
- `busy` out 1: sequence in progress or result pending.
- `pred` out CLS_W: argmax class index.
- `pred_score` out 8: score of `pred`.
- `pred_valid` out 1: result available.
- `pred_ready` in 1: consumer accepts the result.

## Operation
- FSM states:
  - IDLE: `busy=0`. `start=1` → ISSUE.
  - ISSUE: `cls_sel` counts 0..NUM_CLASSES-1, one per cycle, with `cls_sel_valid=1`. After the issue of NUM_CLASSES-1 → DRAIN.
  - DRAIN: `cls_sel_valid=0`. Waits until the last tag returns, then → HOLD.
  - HOLD: `pred_valid=1`.
    - `pred_valid & pred_ready` → IDLE.
    - If `start=1` in that same cycle → ISSUE directly (back-to-back inference).
- Tag pipeline: a LATENCY-deep shift register of {valid, class index}, loaded from {`cls_sel_valid`, `cls_sel`}. When its output is valid, `score` belongs to that class.
- Argmax update:
  - The first returning class (index 0) loads `best_score`/`best_idx` unconditionally.
  - Later classes replace them only if `score > best_score` (strict, unsigned). Ties keep the lower index.
  - Unsigned compare is correct because of the 128 bias.
- `pred`/`pred_score` are the argmax registers. They are stable throughout HOLD regardless of `pred_ready`.
- `start` while `busy=1` is dropped, not queued. The HOLD back-to-back case is the only exception.
- `score` is not sampled when the tag output is invalid; its value is don't-care then.
- Reset, including mid-ISSUE/DRAIN/HOLD:
  - State → IDLE, tag pipeline cleared.
  - All outputs 0: `cls_sel=0`, `cls_sel_valid=0`, `busy=0`, `pred=0`, `pred_score=0`, `pred_valid=0`.
  - No partial result is ever presented after reset.

## Timing
- Edge 0 is the edge that samples `start=1` in IDLE. All outputs are registered.
- After edge k (0 ≤ k < NUM_CLASSES): `cls_sel=k`, `cls_sel_valid=1`.
- Score for class k is sampled at edge k+LATENCY+1.
- The last compare occurs at edge NUM_CLASSES+LATENCY.
- `pred_valid=1` after edge NUM_CLASSES+LATENCY. Default values: after edge 12.
- `busy=1` from after edge 0 until the edge that completes the handshake. It stays 1 on a back-to-back start.
- Back-to-back start: `cls_sel=0`, `cls_sel_valid=1` after the handshake edge, with no idle bubble.
- Throughput is one inference per NUM_CLASSES+LATENCY+1 cycles when `pred_ready` is held high.

## Test plan
- **Reset:** assert `rst` asynchronously mid-cycle → all outputs 0 immediately, no clock needed. Deassert, idle 5 cycles → `busy=0`, `cls_sel_valid=0`.
- **Basic argmax:** model `counter_adder` with a 2-cycle delay; class 7 scores 200, all others 100. Pulse `start` → `cls_sel` 0..9 after edges 0..9. `pred_valid` rises after edge 12 with `pred=7`, `pred_score=200`.
- **Tie and floor:**
  - Classes 2 and 5 both score 250, others 128 → `pred=2`, `pred_score=250`.
  - Separate run with all scores 0 → `pred=0`, `pred_score=0`.
- **Backpressure / ignored start:**
  - Hold `pred_ready=0` for 6 cycles in HOLD → `pred`/`pred_score`/`pred_valid` stable.
  - Pulse `start` during ISSUE and during HOLD (ready low) → no restart, no change in sequence.
- **Back-to-back:** `pred_ready=1` and `start=1` in the same HOLD cycle → `pred_valid=0` and `cls_sel=0`, `cls_sel_valid=1` after that edge. Second inference with class 9 = 255 → `pred=9`.
- **Reset mid-operation:** assert `rst` while `cls_sel=4`, release, then let the stale `score` input keep toggling → no `pred_valid` until a new `start`. A fresh run then gives the correct argmax.
